// File: rtl/lcd_tile_sequencer_if.sv
// Tile request and LCD byte-stream bundle for lcd_tile_sequencer.
// master drives requests and out_ready; slave is the sequencer.
interface lcd_tile_sequencer_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic          tile_valid;
    logic          tile_ready;
    logic [XW-1:0] tile_x;
    logic [YW-1:0] tile_y;
    logic [2:0]    obj_code;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_dcx;

    modport master (
        output tile_valid, tile_x, tile_y, obj_code, out_ready,
        input  tile_ready, out_valid, out_data, out_dcx
    );

    modport slave (
        input  tile_valid, tile_x, tile_y, obj_code, out_ready,
        output tile_ready, out_valid, out_data, out_dcx
    );
endinterface

// File: rtl/lcd_tile_sequencer.sv
// ILI9341 8080-mode init + tile-fill byte sequencer.
// Optional full-screen clear after init: define CLEAR_ON_INIT_EN.
module lcd_tile_sequencer #(
    parameter int TILE_W    = 20,
    parameter int TILE_H    = 20,
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 12,
    parameter int DELAY_CYC = 60000,
    parameter int XW        = 4,
    parameter int YW        = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_start_i,
    lcd_tile_sequencer_if.slave bus,
    output logic busy_o,
    output logic init_done_o,
    output logic tile_done_o,
    output logic tile_err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] M_INIT = 2'd0;
    localparam logic [1:0] M_TILE = 2'd1;
    localparam logic [1:0] M_CLR  = 2'd2;
    localparam int NPIX = TILE_W * TILE_H;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int DW   = $clog2(DELAY_CYC + 1);
    localparam logic [3:0] ST_PIX = 4'd11;
`ifdef CLEAR_ON_INIT_EN
    localparam int NCLR = GRID_COLS * TILE_W * GRID_ROWS * TILE_H;
    localparam int CW   = $clog2(NCLR + 1);
    logic [CW-1:0] clr_q, clr_d;
`endif

    logic [1:0]    state_q, state_d, mode_q, mode_d;
    logic [3:0]    step_q, step_d;
    logic          lo_q, lo_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    obj_q, obj_d;
    logic          init_done_q, init_done_d;
    logic          tile_err_q, tile_err_d;

    logic [15:0] sc, ec, sp, ep, colour;
    logic [7:0]  byte_c;
    logic        dcx_c, xfer, last_px, oob;

    always_comb begin
        sc = 16'(x_q) * 16'(TILE_W);
        ec = sc + 16'(TILE_W - 1);
        sp = 16'(y_q) * 16'(TILE_H);
        ep = sp + 16'(TILE_H - 1);
        unique case (obj_q)
            3'd1:    colour = 16'h1E90;
            3'd2:    colour = 16'h1568;
            3'd3:    colour = 16'hF800;
            3'd4:    colour = 16'h1408;
            default: colour = 16'h0814;
        endcase
`ifdef CLEAR_ON_INIT_EN
        if (mode_q == M_CLR) begin
            sc     = 16'd0;
            ec     = 16'(GRID_COLS * TILE_W - 1);
            sp     = 16'd0;
            ep     = 16'(GRID_ROWS * TILE_H - 1);
            colour = 16'h0814;
        end
`endif
    end

    // Init bytes come from a fixed list; tile/clear share one header layout.
    always_comb begin
        byte_c = 8'h00;
        dcx_c  = 1'b1;
        if (mode_q == M_INIT) begin
            unique case (step_q)
                4'd0:    begin byte_c = 8'h01; dcx_c = 1'b0; end
                4'd1:    begin byte_c = 8'h28; dcx_c = 1'b0; end
                4'd2:    begin byte_c = 8'h3A; dcx_c = 1'b0; end
                4'd3:    byte_c = 8'h55;
                4'd4:    begin byte_c = 8'h11; dcx_c = 1'b0; end
                default: begin byte_c = 8'h29; dcx_c = 1'b0; end
            endcase
        end else begin
            unique case (step_q)
                4'd0:    begin byte_c = 8'h2A; dcx_c = 1'b0; end
                4'd1:    byte_c = sc[15:8];
                4'd2:    byte_c = sc[7:0];
                4'd3:    byte_c = ec[15:8];
                4'd4:    byte_c = ec[7:0];
                4'd5:    begin byte_c = 8'h2B; dcx_c = 1'b0; end
                4'd6:    byte_c = sp[15:8];
                4'd7:    byte_c = sp[7:0];
                4'd8:    byte_c = ep[15:8];
                4'd9:    byte_c = ep[7:0];
                4'd10:   begin byte_c = 8'h2C; dcx_c = 1'b0; end
                default: byte_c = lo_q ? colour[7:0] : colour[15:8];
            endcase
        end
    end

    assign bus.out_valid  = (state_q == S_EMIT);
    assign bus.out_data   = bus.out_valid ? byte_c : 8'h00;
    assign bus.out_dcx    = bus.out_valid & dcx_c;
    assign bus.tile_ready = (state_q == S_IDLE) & init_done_q;
    assign busy_o         = (state_q != S_IDLE);
    assign init_done_o    = init_done_q;
    assign tile_err_o     = tile_err_q;

    assign xfer = bus.out_valid & bus.out_ready;
    assign oob  = (32'(bus.tile_x) >= 32'(GRID_COLS)) ||
                  (32'(bus.tile_y) >= 32'(GRID_ROWS));
`ifdef CLEAR_ON_INIT_EN
    assign last_px = lo_q & ((mode_q == M_CLR) ? (clr_q == CW'(NCLR - 1))
                                               : (pix_q == PW'(NPIX - 1)));
`else
    assign last_px = lo_q & (pix_q == PW'(NPIX - 1));
`endif
    assign tile_done_o = xfer & (mode_q == M_TILE) & (step_q == ST_PIX) & last_px;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        step_d      = step_q;
        lo_d        = lo_q;
        pix_d       = pix_q;
        dly_d       = dly_q;
        x_d         = x_q;
        y_d         = y_q;
        obj_d       = obj_q;
        init_done_d = init_done_q;
        tile_err_d  = 1'b0;
`ifdef CLEAR_ON_INIT_EN
        clr_d       = clr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.tile_valid && bus.tile_ready) begin
                    x_d   = bus.tile_x;
                    y_d   = bus.tile_y;
                    obj_d = bus.obj_code;
                    if (oob) begin
                        tile_err_d = 1'b1;
                    end else begin
                        state_d = S_EMIT;
                        mode_d  = M_TILE;
                        step_d  = 4'd0;
                    end
                end else if (init_start_i) begin
                    state_d = S_EMIT;
                    mode_d  = M_INIT;
                    step_d  = 4'd0;
                end
            end
            S_WAIT: begin
                if (dly_q == DW'(DELAY_CYC - 1)) begin
                    dly_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    if (mode_q == M_INIT) begin
                        step_d = step_q + 4'd1;
                        if (step_q == 4'd0 || step_q == 4'd4) begin
                            state_d = S_WAIT;
                        end else if (step_q == 4'd5) begin
                            step_d = 4'd0;
`ifdef CLEAR_ON_INIT_EN
                            mode_d = M_CLR;
`else
                            state_d     = S_IDLE;
                            init_done_d = 1'b1;
`endif
                        end
                    end else if (step_q != ST_PIX) begin
                        step_d = step_q + 4'd1;
                    end else if (!lo_q) begin
                        lo_d = 1'b1;
                    end else begin
                        lo_d = 1'b0;
                        if (last_px) begin
                            state_d = S_IDLE;
                            step_d  = 4'd0;
                            pix_d   = '0;
`ifdef CLEAR_ON_INIT_EN
                            clr_d   = '0;
`endif
                            if (mode_q == M_CLR) init_done_d = 1'b1;
`ifdef CLEAR_ON_INIT_EN
                        end else if (mode_q == M_CLR) begin
                            clr_d = clr_q + 1'b1;
`endif
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= M_INIT;
            step_q      <= 4'd0;
            lo_q        <= 1'b0;
            pix_q       <= '0;
            dly_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            obj_q       <= 3'd0;
            init_done_q <= 1'b0;
            tile_err_q  <= 1'b0;
`ifdef CLEAR_ON_INIT_EN
            clr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            lo_q        <= lo_d;
            pix_q       <= pix_d;
            dly_q       <= dly_d;
            x_q         <= x_d;
            y_q         <= y_d;
            obj_q       <= obj_d;
            init_done_q <= init_done_d;
            tile_err_q  <= tile_err_d;
`ifdef CLEAR_ON_INIT_EN
            clr_q       <= clr_d;
`endif
        end
    end
endmodule

// File: tb/tb_lcd_tile_sequencer.sv
// Directed scoreboard bench for lcd_tile_sequencer (default build,
// 16x12 grid of 20x20 tiles, short init delay).
module tb_lcd_tile_sequencer;
    localparam int TW = 20;
    localparam int TH = 20;
    localparam int NP = TW * TH;
    localparam int DLY = 8;

    logic clk = 1'b0;
    logic rst;
    logic init_start;
    logic busy, init_done, tile_done, tile_err;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc;
    logic [9:0] sb[$];
    int   stamps[$];
    logic       hold_v = 1'b0;
    logic [8:0] hold_b = 9'd0;

    lcd_tile_sequencer_if #(.XW(4), .YW(4)) ifc ();

    lcd_tile_sequencer #(
        .TILE_W(TW), .TILE_H(TH), .GRID_COLS(16), .GRID_ROWS(12),
        .DELAY_CYC(DLY), .XW(4), .YW(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .init_start_i(init_start),
        .bus(ifc),
        .busy_o(busy),
        .init_done_o(init_done),
        .tile_done_o(tile_done),
        .tile_err_o(tile_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfer monitor: pops the scoreboard and checks stall stability.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && ifc.out_valid)
                check("stall_hold", {ifc.out_dcx, ifc.out_data}, hold_b);
            if (ifc.out_valid && ifc.out_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("byte", {ifc.out_dcx, ifc.out_data}, e[8:0]);
                    check("tile_done", tile_done, e[9]);
                end
                stamps.push_back(cyc);
            end
            hold_v <= ifc.out_valid && !ifc.out_ready;
            hold_b <= {ifc.out_dcx, ifc.out_data};
        end
    end

    task automatic push_init();
        sb.push_back({2'b00, 8'h01});
        sb.push_back({2'b00, 8'h28});
        sb.push_back({2'b00, 8'h3A});
        sb.push_back({2'b01, 8'h55});
        sb.push_back({2'b00, 8'h11});
        sb.push_back({2'b00, 8'h29});
    endtask

    task automatic push_tile(input int x, input int y, input logic [2:0] obj);
        logic [15:0] sc, ec, sp, ep, c;
        sc = 16'(x * TW);
        ec = 16'(x * TW + TW - 1);
        sp = 16'(y * TH);
        ep = 16'(y * TH + TH - 1);
        case (obj)
            3'd1:    c = 16'h1E90;
            3'd2:    c = 16'h1568;
            3'd3:    c = 16'hF800;
            3'd4:    c = 16'h1408;
            default: c = 16'h0814;
        endcase
        sb.push_back({2'b00, 8'h2A});
        sb.push_back({2'b01, sc[15:8]});
        sb.push_back({2'b01, sc[7:0]});
        sb.push_back({2'b01, ec[15:8]});
        sb.push_back({2'b01, ec[7:0]});
        sb.push_back({2'b00, 8'h2B});
        sb.push_back({2'b01, sp[15:8]});
        sb.push_back({2'b01, sp[7:0]});
        sb.push_back({2'b01, ep[15:8]});
        sb.push_back({2'b01, ep[7:0]});
        sb.push_back({2'b00, 8'h2C});
        for (int i = 0; i < NP; i++) begin
            sb.push_back({2'b01, c[15:8]});
            sb.push_back({(i == NP - 1), 1'b1, c[7:0]});
        end
    endtask

    task automatic send_tile(input int x, input int y, input logic [2:0] obj,
                             output int a);
        ifc.tile_x     = 4'(x);
        ifc.tile_y     = 4'(y);
        ifc.obj_code   = obj;
        ifc.tile_valid = 1'b1;
        @(negedge clk);
        check("tile_ready_pre", ifc.tile_ready, 1);
        @(posedge clk);
        #1;
        ifc.tile_valid = 1'b0;
        a = cyc;
    endtask

    task automatic wait_idle(input string tag, input int bound, input bit rnd);
        int n = 0;
        while ((busy || sb.size() != 0) && n < bound) begin
            @(posedge clk);
            #1;
            if (rnd) ifc.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check(tag, n < bound, 1);
        ifc.out_ready = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        init_start     = 1'b0;
        ifc.tile_valid = 1'b0;
        ifc.tile_x     = 4'd0;
        ifc.tile_y     = 4'd0;
        ifc.obj_code   = 3'd0;
        ifc.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_tile_ready", ifc.tile_ready, 0);
        check("rst_tile_err", tile_err, 0);
        check("rst_data_dcx", {ifc.out_dcx, ifc.out_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Request before init must stall.
        ifc.tile_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_init_ready", ifc.tile_ready, 0);
        check("pre_init_busy", busy, 0);
        @(posedge clk);
        #1 ifc.tile_valid = 1'b0;

        // Init sequence.
        stamps.delete();
        push_init();
        init_start = 1'b1;
        @(posedge clk);
        #1 init_start = 1'b0;
        check("init_tile_ready_busy", ifc.tile_ready, 0);
        wait_idle("init_timeout", 200, 1'b0);
        check("init_done", init_done, 1);
        check("init_count", stamps.size(), 6);
        if (stamps.size() == 6) begin
            check("gap_swreset", stamps[1] - stamps[0], DLY + 1);
            check("gap_slpout", stamps[5] - stamps[4], DLY + 1);
        end

        // Tile 2,1 apple with init_start pulsed while busy.
        stamps.delete();
        push_tile(2, 1, 3'd3);
        send_tile(2, 1, 3'd3, acc);
        init_start = 1'b1;
        repeat (5) @(posedge clk);
        #1 init_start = 1'b0;
        wait_idle("tile2_timeout", 2000, 1'b0);
        check("tile2_count", stamps.size(), 11 + 2 * NP);
        if (stamps.size() == 11 + 2 * NP) begin
            check("tile2_first", stamps[0], acc);
            check("tile2_b2b", stamps[10 + 2 * NP] - stamps[0], 10 + 2 * NP);
        end
        check("tile2_ready_after", ifc.tile_ready, 1);
        check("tile2_busy_after", busy, 0);

        // Same tile with random backpressure.
        stamps.delete();
        push_tile(2, 1, 3'd3);
        send_tile(2, 1, 3'd3, acc);
        wait_idle("tile3_timeout", 6000, 1'b1);
        check("tile3_count", stamps.size(), 11 + 2 * NP);

        // Corner tile, obj 6, init_start coincident: tile wins.
        stamps.delete();
        push_tile(15, 11, 3'd6);
        init_start = 1'b1;
        send_tile(15, 11, 3'd6, acc);
        init_start = 1'b0;
        wait_idle("tile4_timeout", 2000, 1'b0);
        check("tile4_count", stamps.size(), 11 + 2 * NP);

        // Out-of-range requests.
        for (int k = 0; k < 2; k++) begin
            stamps.delete();
            send_tile(k == 0 ? 3 : 15, k == 0 ? 12 : 15, 3'd1, acc);
            check("oob_err", tile_err, 1);
            check("oob_valid", ifc.out_valid, 0);
            check("oob_busy", busy, 0);
            check("oob_ready", ifc.tile_ready, 1);
            @(posedge clk);
            #1;
            check("oob_err_clear", tile_err, 0);
            check("oob_no_bytes", stamps.size(), 0);
        end

        // Reset mid-pixel.
        push_tile(1, 1, 3'd2);
        send_tile(1, 1, 3'd2, acc);
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", ifc.out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_init_done", init_done, 0);
        check("mid_rst_ready", ifc.tile_ready, 0);
        sb.delete();
        rst = 1'b0;
        ifc.tile_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_ready", ifc.tile_ready, 0);
            check("post_rst_valid", ifc.out_valid, 0);
        end
        ifc.tile_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
